// File: rtl/fios_pkg.sv
// ============================================================================
// Module   : fios_pkg
// Brief    : Shared types and helpers for the FIOS result-reduction slice.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fios_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SELECT  = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  localparam int FIOS_WORD_WIDTH = 17;

  typedef logic [FIOS_WORD_WIDTH-1:0] word_t;

  // Counter width that never collapses to zero bits for tiny word counts.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fios_res_reduce_if.sv
// ============================================================================
// Module   : fios_res_reduce_if
// Brief    : Result-stream, modulus-load and drain handshake bundle.
//            ovf_o exists only when FIOS_RES_REDUCE_OVF_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fios_res_reduce_if #(
  parameter int WORD_WIDTH = 17
);

  logic                  p_load_i;
  logic [WORD_WIDTH-1:0] p_word_i;
  logic                  RES_push_i;
  logic [WORD_WIDTH-1:0] RES_i;
  logic                  done_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [WORD_WIDTH-1:0] out_word_o;
  logic                  out_last_o;
  logic                  busy_o;
`ifdef FIOS_RES_REDUCE_OVF_EN
  logic                  ovf_o;
`endif

  modport master (
    output p_load_i, p_word_i, RES_push_i, RES_i, done_i, out_ready_i,
    input  out_valid_o, out_word_o, out_last_o, busy_o
`ifdef FIOS_RES_REDUCE_OVF_EN
    , input ovf_o
`endif
  );

  modport slave (
    input  p_load_i, p_word_i, RES_push_i, RES_i, done_i, out_ready_i,
    output out_valid_o, out_word_o, out_last_o, busy_o
`ifdef FIOS_RES_REDUCE_OVF_EN
    , output ovf_o
`endif
  );

endinterface

`default_nettype wire

// File: rtl/fios_sub_word.sv
// ============================================================================
// Module   : fios_sub_word
// Brief    : One word of a ripple subtractor: a - b - bin with borrow-out.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fios_sub_word #(
  parameter int WORD_WIDTH = 17
) (
  input  logic [WORD_WIDTH-1:0] i_a,
  input  logic [WORD_WIDTH-1:0] i_b,
  input  logic                  i_bin,
  output logic [WORD_WIDTH-1:0] o_diff,
  output logic                  o_bout
);

  logic [WORD_WIDTH:0] w_full;

  // The extra MSB goes high exactly when a < b + bin.
  assign w_full = {1'b0, i_a} - {1'b0, i_b} - {{WORD_WIDTH{1'b0}}, i_bin};
  assign o_diff = w_full[WORD_WIDTH-1:0];
  assign o_bout = w_full[WORD_WIDTH];

endmodule

`default_nettype wire

// File: rtl/fios_res_reduce.sv
// ============================================================================
// Module   : fios_res_reduce
// Brief    : Captures the word-serial Montgomery result, forms RES - p on the
//            fly and drains the fully reduced value. Optional sticky protocol
//            error flag under FIOS_RES_REDUCE_OVF_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fios_res_reduce
  import fios_pkg::*;
#(
  parameter int S          = 8,
  parameter int WORD_WIDTH = 17
) (
  input  logic                clock_i,
  input  logic                reset_i,
  fios_res_reduce_if.slave    bus
);

  localparam int            KW     = clog2_min1(S);
  localparam logic [KW-1:0] c_LAST = KW'(S - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [KW-1:0]         r_k;
  logic [KW-1:0]         r_j;
  logic [KW-1:0]         r_pptr;
  logic                  r_borrow;
  logic                  r_sel_d;
  logic [WORD_WIDTH-1:0] r_p [S];
  logic [WORD_WIDTH-1:0] r_r [S];
  logic [WORD_WIDTH-1:0] r_d [S];
  logic                  r_out_valid;
  logic [WORD_WIDTH-1:0] r_out_word;
  logic                  r_out_last;
  logic                  w_busy;

  logic                  w_accept;
  logic                  w_bin;
  logic [WORD_WIDTH-1:0] w_diff;
  logic                  w_bout;
  logic                  w_xfer;
  logic [KW-1:0]         w_j_nxt;

  assign w_accept = bus.RES_push_i && ((r_state == IDLE) || (r_state == COLLECT));
  // A new operation always starts its borrow chain from zero.
  assign w_bin    = (r_state == IDLE) ? 1'b0 : r_borrow;
  assign w_xfer   = (r_state == DRAIN) && r_out_valid && bus.out_ready_i;
  assign w_j_nxt  = r_j + 1'b1;

  fios_sub_word #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_sub (
    .i_a    (bus.RES_i),
    .i_b    (r_p[r_k]),
    .i_bin  (w_bin),
    .o_diff (w_diff),
    .o_bout (w_bout)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.RES_push_i) w_state_nxt = (r_k == c_LAST) ? SELECT : COLLECT;
      COLLECT: if (bus.RES_push_i && (r_k == c_LAST)) w_state_nxt = SELECT;
      SELECT:  w_state_nxt = DRAIN;
      DRAIN:   if (w_xfer && (r_j == c_LAST)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state != IDLE);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int i = 0; i < S; i++) begin
        r_p[i] <= '0;
        r_r[i] <= '0;
        r_d[i] <= '0;
      end
      r_k         <= '0;
      r_j         <= '0;
      r_pptr      <= '0;
      r_borrow    <= 1'b0;
      r_sel_d     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_word  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (bus.p_load_i && (r_state == IDLE)) begin
        r_p[r_pptr] <= bus.p_word_i;
        r_pptr      <= (r_pptr == c_LAST) ? '0 : r_pptr + 1'b1;
      end
      if (w_accept) begin
        r_r[r_k] <= bus.RES_i;
        r_d[r_k] <= w_diff;
        r_borrow <= w_bout;
        r_k      <= (r_k == c_LAST) ? '0 : r_k + 1'b1;
      end
      if (r_state == SELECT) begin
        r_sel_d     <= ~r_borrow;
        r_j         <= '0;
        r_out_valid <= 1'b1;
        r_out_word  <= r_borrow ? r_r[0] : r_d[0];
        r_out_last  <= (c_LAST == '0);
      end else if (w_xfer) begin
        if (r_j == c_LAST) begin
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
        end else begin
          r_j        <= w_j_nxt;
          r_out_word <= r_sel_d ? r_d[w_j_nxt] : r_r[w_j_nxt];
          r_out_last <= (w_j_nxt == c_LAST);
        end
      end
    end
  end

  assign bus.out_valid_o = r_out_valid;
  assign bus.out_word_o  = r_out_word;
  assign bus.out_last_o  = r_out_last;
  assign bus.busy_o      = w_busy;

`ifdef FIOS_RES_REDUCE_OVF_EN
  logic r_ovf;
  logic w_err;

  assign w_err = (bus.RES_push_i && ((r_state == SELECT) || (r_state == DRAIN))) ||
                 (bus.done_i && (r_state == COLLECT) && (r_k != c_LAST));

  always_ff @(posedge clock_i) begin
    if (reset_i)    r_ovf <= 1'b0;
    else if (w_err) r_ovf <= 1'b1;
  end

  assign bus.ovf_o = r_ovf;
`else
  logic w_unused_done;
  assign w_unused_done = bus.done_i;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fios_res_reduce.sv
// ============================================================================
// Module   : tb_fios_res_reduce
// Brief    : Directed-vector bench for fios_res_reduce with S=2, W=17.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fios_res_reduce;
  import fios_pkg::*;

  localparam int S  = 2;
  localparam int WW = 17;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  fios_res_reduce_if #(.WORD_WIDTH(WW)) bus_if ();

  fios_res_reduce #(
    .S          (S),
    .WORD_WIDTH (WW)
  ) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic load_p(input word_t w0, input word_t w1);
    @(negedge clk);
    bus_if.p_load_i = 1'b1;
    bus_if.p_word_i = w0;
    @(negedge clk);
    bus_if.p_word_i = w1;
    @(negedge clk);
    bus_if.p_load_i = 1'b0;
    bus_if.p_word_i = '0;
  endtask

  // Leaves the bench at the negedge one half-cycle after the last push edge.
  task automatic push_res(input word_t w0, input word_t w1);
    @(negedge clk);
    bus_if.RES_push_i = 1'b1;
    bus_if.RES_i      = w0;
    @(negedge clk);
    bus_if.RES_i      = w1;
    @(negedge clk);
    bus_if.RES_push_i = 1'b0;
    bus_if.RES_i      = '0;
  endtask

  task automatic run_case(input string tag, input word_t r0, input word_t r1,
                          input word_t e0, input word_t e1);
    bus_if.out_ready_i = 1'b1;
    push_res(r0, r1);
    chk({tag, "_select_valid"}, 32'(bus_if.out_valid_o), 32'd0);
    chk({tag, "_select_busy"},  32'(bus_if.busy_o),      32'd1);
    @(negedge clk);
    chk({tag, "_w0_valid"}, 32'(bus_if.out_valid_o), 32'd1);
    chk({tag, "_w0"},       32'(bus_if.out_word_o),  32'(e0));
    chk({tag, "_w0_last"},  32'(bus_if.out_last_o),  32'd0);
    @(negedge clk);
    chk({tag, "_w1_valid"}, 32'(bus_if.out_valid_o), 32'd1);
    chk({tag, "_w1"},       32'(bus_if.out_word_o),  32'(e1));
    chk({tag, "_w1_last"},  32'(bus_if.out_last_o),  32'd1);
    @(negedge clk);
    chk({tag, "_end_valid"}, 32'(bus_if.out_valid_o), 32'd0);
    chk({tag, "_end_busy"},  32'(bus_if.busy_o),      32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst                = 1'b1;
    bus_if.p_load_i    = 1'b0;
    bus_if.p_word_i    = '0;
    bus_if.RES_push_i  = 1'b0;
    bus_if.RES_i       = '0;
    bus_if.done_i      = 1'b0;
    bus_if.out_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_valid", 32'(bus_if.out_valid_o), 32'd0);
    chk("rst_word",  32'(bus_if.out_word_o),  32'd0);
    chk("rst_last",  32'(bus_if.out_last_o),  32'd0);
    chk("rst_busy",  32'(bus_if.busy_o),      32'd0);
`ifdef FIOS_RES_REDUCE_OVF_EN
    chk("rst_ovf",   32'(bus_if.ovf_o),       32'd0);
`endif

    load_p(17'h00005, 17'h00000);

    run_case("t1_sub", 17'h00007, 17'h00000, 17'h00002, 17'h00000);

    run_case("t2_keep", 17'h00003, 17'h00000, 17'h00003, 17'h00000);
    chk("t2_d0",     32'(dut.r_d[0]),    32'h1FFFE);
    chk("t2_d1",     32'(dut.r_d[1]),    32'h1FFFF);
    chk("t2_borrow", 32'(dut.r_borrow),  32'd1);

    run_case("t3_equal", 17'h00005, 17'h00000, 17'h00000, 17'h00000);

    // Backpressure: output must hold steady while ready is low.
    bus_if.out_ready_i = 1'b0;
    push_res(17'h00007, 17'h00000);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", 32'(bus_if.out_valid_o), 32'd1);
      chk("t4_hold_word",  32'(bus_if.out_word_o),  32'h00002);
      @(negedge clk);
    end
`ifdef FIOS_RES_REDUCE_OVF_EN
    bus_if.RES_push_i = 1'b1;
    bus_if.RES_i      = 17'h1ABCD;
    @(negedge clk);
    bus_if.RES_push_i = 1'b0;
    bus_if.RES_i      = '0;
    chk("t5_ovf",       32'(bus_if.ovf_o),      32'd1);
    chk("t5_word_kept", 32'(bus_if.out_word_o), 32'h00002);
    chk("t5_last_kept", 32'(bus_if.out_last_o), 32'd0);
`endif
    bus_if.out_ready_i = 1'b1;
    @(negedge clk);
    chk("t4_w1",      32'(bus_if.out_word_o),  32'h00000);
    chk("t4_w1_last", 32'(bus_if.out_last_o),  32'd1);
    @(negedge clk);
    chk("t4_end_valid", 32'(bus_if.out_valid_o), 32'd0);
    chk("t4_end_busy",  32'(bus_if.busy_o),      32'd0);
`ifdef FIOS_RES_REDUCE_OVF_EN
    chk("t5_ovf_sticky", 32'(bus_if.ovf_o), 32'd1);
`endif

    // Abort after one of two pushes.
    @(negedge clk);
    bus_if.RES_push_i = 1'b1;
    bus_if.RES_i      = 17'h00007;
    @(negedge clk);
    bus_if.RES_push_i = 1'b0;
    bus_if.RES_i      = '0;
    chk("t6_mid_busy", 32'(bus_if.busy_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rst_busy",  32'(bus_if.busy_o),      32'd0);
    chk("t6_rst_valid", 32'(bus_if.out_valid_o), 32'd0);
    chk("t6_rst_word",  32'(bus_if.out_word_o),  32'd0);
    chk("t6_rst_last",  32'(bus_if.out_last_o),  32'd0);
    chk("t6_rst_p0",    32'(dut.r_p[0]),         32'd0);
`ifdef FIOS_RES_REDUCE_OVF_EN
    chk("t6_rst_ovf",   32'(bus_if.ovf_o),       32'd0);
`endif
    load_p(17'h00003, 17'h00001);
    run_case("t6_fresh", 17'h00001, 17'h00002, 17'h1FFFE, 17'h00000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
